controlador_ascensor: RTL and testbench
=======================================

// Module: controlador_ascensor
// PURPOSE
//  Sequencing controller for the 4-floor elevator. Latches button presses into a pending
//  request vector, runs a SCAN (collective) up/down policy, times floor-to-floor travel
//  and door dwell, and drives solicitudes/estado straight into interfaz_de_salida.
// PARAMETERS
//  TRAVEL_CYCLES  16  clock cycles to move one floor (>=1)
//  DOOR_CYCLES    32  clock cycles door stays open at a served floor (>=1)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset_n      in   1   asynchronous active-low reset
//  botones      in   10  button pulses, 1 = pressed this cycle (bit map below)
//  solicitudes  out  10  pending (latched, not yet served) requests, same bit map
//  estado       out  4   [1:0] floor 0..3, [2] dir (0 up, 1 down), [3] moving
//  puerta       out  1   1 = door open
// BEHAVIOUR
//  Bit map: [3:0] cabin floor 0..3; [6:4] up call floors 0..2; [9:7] down call floors 1..3.
//  Reset (async, reset_n=0): solicitudes=0, estado=4'b0000 (floor 0, up, stopped), puerta=0,
//   FSM=IDLE, timer=0. Outputs registered; all change only on clk rising edge after release.
//  Latching: solicitudes <= (solicitudes | botones) & ~clear, where clear = bits served this
//   cycle. A press on a bit being cleared in the same cycle is dropped (already served).
//  "Above"/"below" = any pending bit (cabin or either hall call) for a floor >/< current floor.
//  States:
//   IDLE: estado[3]=0, puerta=0.
//    - request at current floor (cabin, or either hall call) -> DOOR, clear those bits.
//    - else dir=up: above ? MOVING : below ? (dir<=down, MOVING) : stay.
//    - dir=down mirrors (checks below first). MOVING entry loads timer=TRAVEL_CYCLES-1.
//   MOVING: estado[3]=1; timer decrements each cycle; at 0 floor +=1 (up) or -=1 (down),
//    then ARRIVE evaluation in the same cycle as the floor update:
//    - stop if cabin bit for new floor, or hall call in current dir for new floor, or no
//      further requests beyond new floor in current dir (also stop at floor 0/3).
//    - stop -> DOOR; else reload timer, stay MOVING.
//   DOOR: puerta=1, estado[3]=0, timer loaded DOOR_CYCLES-1 on entry.
//    - On entry clear cabin bit of floor + hall call in current dir. If nothing pending beyond
//      floor in current dir: reverse dir and also clear the opposite hall call of that floor.
//    - New press for current floor while in DOOR (cabin or current-dir hall) is cleared and
//      reloads timer (door held open).
//    - timer 0 -> IDLE, puerta<=0.
//  Floor arithmetic 2-bit; never wraps: floor 3 forces dir=down, floor 0 forces dir=up.
//  Non-existent calls (up@3, down@0) have no bits; never generated.
//  Simultaneous above and below requests: current dir wins; reverse only when none remain.
//  Reset mid-travel or with door open: immediate return to reset values; pending lost.
//  Timer width $clog2(max(TRAVEL_CYCLES,DOOR_CYCLES))+1 bits; unsigned.
// TESTING
//  1 reset, no presses 100 cycles -> solicitudes=0, estado=0000, puerta=0 throughout.
//  2 IDLE@0, botones[2] pulse -> solicitudes=0x004; estado=1000, after 2*16 cycles
//    floor=2, puerta=1, solicitudes=0; after 32 more cycles puerta=0, estado=0010.
//  3 IDLE@0, press cabin3 then up-call@1 (bit4) while moving -> stops at 1 (door, bit4
//    cleared, bit3 kept), continues to 3, dir becomes down at 3, solicitudes=0 at end.
//  4 car@2 moving up to 3, down-call@1 (bit7) pending -> does not stop at 1 on way up;
//    after 3 reverses to down, estado[2]=1, serves floor 1, bit7 cleared there.
//  5 DOOR@1, press cabin1 at cycle 20 of dwell -> bit not latched, door stays open
//    32 further cycles; reset_n=0 mid-MOVING -> all outputs 0 same cycle (async).

Source files
------------

// File: rtl/controlador_ascensor.sv
// Elevator sequencing controller: latches hall/cabin calls, runs a SCAN
// (collective) up/down policy, and times floor travel and door dwell.
module controlador_ascensor #(
   parameter int unsigned TRAVEL_CYCLES = 16,
   parameter int unsigned DOOR_CYCLES   = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] botones,
   output logic [9:0] solicitudes,
   output logic [3:0] estado,
   output logic       puerta
);

   localparam int unsigned MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int unsigned TW = $clog2(MAX_CYCLES) + 1;
   localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MOVING,
      ST_DOOR
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    floor_q, floor_d;
   logic          dir_q, dir_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [9:0]    sol_q, sol_d;
   logic          moving_q, moving_d;
   logic          puerta_q, puerta_d;

   logic [9:0]    clr;
   logic [9:0]    rem;
   logic [1:0]    nxt_floor;
   logic          nxt_dir;

   // Collapse the request vector into one "someone wants this floor" bit per floor.
   function automatic logic [3:0] floors_of(input logic [9:0] r);
      return r[3:0] | {1'b0, r[6:4]} | {r[9:7], 1'b0};
   endfunction

   function automatic logic [9:0] cabin_bit(input logic [1:0] f);
      return 10'h001 << f;
   endfunction

   // Hall call for floor f in direction d; zero where the button does not exist.
   function automatic logic [9:0] hall_bit(input logic [1:0] f, input logic d);
      logic [9:0] m;
      m = '0;
      if (!d && f != 2'd3)
         m = 10'h010 << f;
      else if (d && f != 2'd0)
         m = 10'h040 << f;
      return m;
   endfunction

   // Any request strictly beyond floor f in direction d.
   function automatic logic beyond(input logic [9:0] r, input logic [1:0] f, input logic d);
      logic [3:0] fl;
      fl = floors_of(r);
      if (d)
         return |(fl & ((4'b0001 << f) - 4'd1));
      else
         return |(fl & (4'b1110 << f));
   endfunction

   // Next-state logic: SCAN decisions, served-bit clearing and timers.
   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      dir_d     = dir_q;
      timer_d   = timer_q;
      clr       = '0;
      rem       = '0;
      nxt_floor = floor_q;
      nxt_dir   = dir_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|(sol_q & (cabin_bit(floor_q) | hall_bit(floor_q, 1'b0) | hall_bit(floor_q, 1'b1)))) begin
               clr     = cabin_bit(floor_q) | hall_bit(floor_q, 1'b0) | hall_bit(floor_q, 1'b1);
               state_d = ST_DOOR;
               timer_d = DOOR_LOAD;
            end else if (beyond(sol_q, floor_q, dir_q)) begin
               state_d = ST_MOVING;
               timer_d = TRAVEL_LOAD;
            end else if (beyond(sol_q, floor_q, ~dir_q)) begin
               dir_d   = ~dir_q;
               state_d = ST_MOVING;
               timer_d = TRAVEL_LOAD;
            end
         end
         ST_MOVING: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TW'(1);
            end else begin
               nxt_floor = dir_q ? floor_q - 2'd1 : floor_q + 2'd1;
               nxt_dir   = (nxt_floor == 2'd3) ? 1'b1 : (nxt_floor == 2'd0) ? 1'b0 : dir_q;
               floor_d   = nxt_floor;
               dir_d     = nxt_dir;
               if (|(sol_q & (cabin_bit(nxt_floor) | hall_bit(nxt_floor, nxt_dir))) ||
                   !beyond(sol_q, nxt_floor, nxt_dir) ||
                   nxt_floor == 2'd0 || nxt_floor == 2'd3) begin
                  // Door entry: reverse only if work remains elsewhere, so an empty
                  // building leaves the direction untouched.
                  clr = cabin_bit(nxt_floor) | hall_bit(nxt_floor, nxt_dir);
                  rem = sol_q & ~clr;
                  if (!beyond(rem, nxt_floor, nxt_dir) && rem != '0) begin
                     dir_d = ~nxt_dir;
                     clr   = clr | hall_bit(nxt_floor, ~nxt_dir);
                  end
                  state_d = ST_DOOR;
                  timer_d = DOOR_LOAD;
               end else begin
                  timer_d = TRAVEL_LOAD;
               end
            end
         end
         ST_DOOR: begin
            clr = cabin_bit(floor_q) | hall_bit(floor_q, dir_q);
            if (|(botones & clr))
               timer_d = DOOR_LOAD;
            else if (timer_q == '0)
               state_d = ST_IDLE;
            else
               timer_d = timer_q - TW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      sol_d    = (sol_q | botones) & ~clr;
      moving_d = (state_d == ST_MOVING);
      puerta_d = (state_d == ST_DOOR);
   end

   // State, request and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         floor_q  <= '0;
         dir_q    <= 1'b0;
         timer_q  <= '0;
         sol_q    <= '0;
         moving_q <= 1'b0;
         puerta_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         dir_q    <= dir_d;
         timer_q  <= timer_d;
         sol_q    <= sol_d;
         moving_q <= moving_d;
         puerta_q <= puerta_d;
      end
   end

   assign solicitudes = sol_q;
   assign estado      = {moving_q, dir_q, floor_q};
   assign puerta      = puerta_q;

endmodule

// File: tb/tb_controlador_ascensor.sv
// Bench for controlador_ascensor: per-floor behavioural model feeds a scoreboard
// queue; a negedge monitor compares the DUT against it every cycle.
module tb_controlador_ascensor;

   localparam int TC = 16;
   localparam int DC = 32;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [9:0] botones;
   logic [9:0] solicitudes;
   logic [3:0] estado;
   logic       puerta;

   always #5 clk = ~clk;

   controlador_ascensor #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .botones    (botones),
      .solicitudes(solicitudes),
      .estado     (estado),
      .puerta     (puerta)
   );

   typedef struct packed {
      logic [9:0] sol;
      logic [3:0] est;
      logic       pu;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: mode 0 idle, 1 travelling, 2 door open; dir 0 up, 1 down.
   int       m_floor, m_dir, m_mode, m_timer;
   bit [9:0] m_req;

   // kind 0 cabin, 1 up call, 2 down call
   function automatic bit [9:0] call_mask(int f, int kind);
      bit [9:0] m;
      m = '0;
      if (kind == 0) m[f] = 1'b1;
      else if (kind == 1 && f < 3) m[4 + f] = 1'b1;
      else if (kind == 2 && f > 0) m[6 + f] = 1'b1;
      return m;
   endfunction

   function automatic bit wants(bit [9:0] r, int f);
      return ((r & (call_mask(f, 0) | call_mask(f, 1) | call_mask(f, 2))) != 0);
   endfunction

   function automatic bit work_toward(bit [9:0] r, int f, int d);
      for (int g = 0; g < 4; g++)
         if (((d == 0 && g > f) || (d == 1 && g < f)) && wants(r, g)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int hall_kind(int d);
      return (d == 0) ? 1 : 2;
   endfunction

   task automatic model_reset();
      m_floor = 0; m_dir = 0; m_mode = 0; m_timer = 0; m_req = '0;
   endtask

   task automatic open_door_after_arrival();
      bit [9:0] clr, rest;
      clr  = call_mask(m_floor, 0) | call_mask(m_floor, hall_kind(m_dir));
      rest = m_req & ~clr;
      if (!work_toward(rest, m_floor, m_dir) && rest != 0) begin
         m_dir = 1 - m_dir;
         clr   = clr | call_mask(m_floor, hall_kind(m_dir));
      end
      m_req   = m_req & ~clr;
      m_mode  = 2;
      m_timer = DC - 1;
   endtask

   task automatic model_step(bit [9:0] b);
      bit [9:0] clr;
      bit [9:0] req_old;
      clr     = '0;
      req_old = m_req;
      m_req   = m_req | b;
      case (m_mode)
         0: begin
            if (wants(req_old, m_floor)) begin
               clr = call_mask(m_floor, 0) | call_mask(m_floor, 1) | call_mask(m_floor, 2);
               m_mode = 2; m_timer = DC - 1;
            end else if (work_toward(req_old, m_floor, m_dir)) begin
               m_mode = 1; m_timer = TC - 1;
            end else if (work_toward(req_old, m_floor, 1 - m_dir)) begin
               m_dir = 1 - m_dir; m_mode = 1; m_timer = TC - 1;
            end
         end
         1: begin
            if (m_timer > 0) m_timer--;
            else begin
               m_floor = m_floor + ((m_dir == 1) ? -1 : 1);
               if (m_floor == 3) m_dir = 1;
               if (m_floor == 0) m_dir = 0;
               if ((req_old & (call_mask(m_floor, 0) | call_mask(m_floor, hall_kind(m_dir)))) != 0 ||
                   !work_toward(req_old, m_floor, m_dir) || m_floor == 0 || m_floor == 3) begin
                  // decisions use the pre-press vector; fresh presses are merged afterwards
                  m_req = req_old;
                  open_door_after_arrival();
                  clr   = ~m_req & req_old;
                  m_req = req_old;
               end else m_timer = TC - 1;
            end
         end
         default: begin
            clr = call_mask(m_floor, 0) | call_mask(m_floor, hall_kind(m_dir));
            if ((b & clr) != 0) m_timer = DC - 1;
            else if (m_timer == 0) m_mode = 0;
            else m_timer--;
         end
      endcase
      m_req = (req_old | b) & ~clr;
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.sol = m_req;
      o.est = {(m_mode == 1), m_dir[0], m_floor[1:0]};
      o.pu  = (m_mode == 2);
      return o;
   endfunction

   // Drive one cycle of button input, advance the model on the edge, queue the expectation.
   task automatic step(bit [9:0] b);
      botones = b;
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step(b);
      exp_q.push_back(model_obs());
      #2;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step('0);
   endtask

   task automatic press(bit [9:0] b);
      step(b);
   endtask

   // Assert reset between edges and confirm outputs clear without waiting for a clock.
   task automatic async_reset_check(string tag);
      #1 reset_n = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      if (solicitudes != '0 || estado != '0 || puerta != 1'b0) begin
         errors++;
         $display("FAIL async_reset_%s: solicitudes=%h estado=%b puerta=%b, required 000/0000/0",
                  tag, solicitudes, estado, puerta);
      end
      model_reset();
      step('0);
      step('0);
      reset_n = 1'b1;
   endtask

   // Monitor: compare the DUT against the oldest queued expectation each cycle.
   initial begin
      obs_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (solicitudes !== e.sol || estado !== e.est || puerta !== e.pu) begin
               errors++;
               $display("FAIL cycle_obs @%0t: solicitudes=%h estado=%b puerta=%b, required %h %b %b",
                        $time, solicitudes, estado, puerta, e.sol, e.est, e.pu);
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by random button traffic.
   initial begin
      bit [9:0] b;
      int       r;
      reset_n = 1'b0;
      botones = '0;
      model_reset();
      idle(3);
      reset_n = 1'b1;

      idle(100);                       // quiet after reset
      press(10'h004); idle(75);        // cabin 2 from floor 0
      press(10'h008); idle(5);         // cabin 3 ...
      press(10'h010); idle(160);       // ... then up call at 1 while travelling
      press(10'h001); idle(130);       // back to floor 0
      press(10'h008); idle(20);        // head for 3
      press(10'h080); idle(200);       // down call at 1 served after reversal
      idle(40);
      press(10'h002); idle(20);        // door at 1 ...
      press(10'h002); idle(45);        // ... cabin 1 again holds it open
      press(10'h008); idle(10);        // travelling
      async_reset_check("moving");

      for (int i = 0; i < 3000; i++) begin
         b = '0;
         r = $urandom_range(0, 19);
         if (r <= 1) b[$urandom_range(0, 9)] = 1'b1;
         if (r == 1) b[$urandom_range(0, 9)] = 1'b1;
         step(b);
         if (i == 1500) async_reset_check("random");
      end
      idle(2);
      #10;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
